// File: rtl/wc_tile_seq.sv
// Winograd-core tile sequencer: loads NIN serial words into a packed tile, fires the core,
// waits the fixed core latency, captures the result and drains NOUT words serially.
module wc_tile_seq #(
  parameter int W    = 10,
  parameter int NIN  = 9,
  parameter int NOUT = 5,
  parameter int LAT  = 3,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [W-1:0]      in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [W*NIN-1:0]  core_d_o,
  output logic              core_start_o,
  input  logic [W*NOUT-1:0] core_z_i,
  output logic [W-1:0]      out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic [CNTW-1:0]   tile_cnt_o
);

  localparam int INW  = (NIN  > 1) ? $clog2(NIN)  : 1;
  localparam int OUTW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int WTW  = $clog2(LAT + 1);

  localparam logic [INW-1:0]  IN_LAST   = INW'(NIN - 1);
  localparam logic [OUTW-1:0] OUT_LAST  = OUTW'(NOUT - 1);
  localparam logic [WTW-1:0]  WAIT_INIT = WTW'(LAT);
  localparam logic [WTW-1:0]  WAIT_ONE  = WTW'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          state_q;
  logic [INW-1:0]  in_idx_q;
  logic [OUTW-1:0] out_idx_q;
  logic [WTW-1:0]  wait_q;
  logic [W-1:0]    core_d_q [NIN];
  logic [W-1:0]    res_q    [NOUT];
  logic            core_start_q;
  logic            out_valid_q;
  logic [CNTW-1:0] tile_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      in_idx_q     <= '0;
      out_idx_q    <= '0;
      wait_q       <= '0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      tile_cnt_q   <= '0;
      // NOTE: both word stores are reset because core_d and out_data have defined
      // reset values; a plain RAM without reset would leave them X after power-up.
      for (int k = 0; k < NIN; k++)  core_d_q[k] <= '0;
      for (int k = 0; k < NOUT; k++) res_q[k]    <= '0;
    end else if (flush_i) begin
      // Abort wins over any handshake this cycle; loaded words and the tile count survive.
      state_q      <= S_LOAD;
      in_idx_q     <= '0;
      out_idx_q    <= '0;
      wait_q       <= '0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      // NOTE: every state register uses <= so all updates see the pre-edge values.
      case (state_q)
        S_LOAD: begin
          if (in_valid_i) begin
            core_d_q[in_idx_q] <= in_data_i;
            if (in_idx_q == IN_LAST) begin
              in_idx_q     <= '0;
              core_start_q <= 1'b1;
              state_q      <= S_FIRE;
            end else begin
              in_idx_q <= in_idx_q + INW'(1);
            end
          end
        end
        S_FIRE: begin
          core_start_q <= 1'b0;
          wait_q       <= WAIT_INIT;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          // Last wait cycle is LAT cycles after the start pulse: core_z is valid now.
          if (wait_q == WAIT_ONE) begin
            for (int k = 0; k < NOUT; k++) res_q[k] <= core_z_i[k*W +: W];
            wait_q      <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_DRAIN;
          end else begin
            wait_q <= wait_q - WAIT_ONE;
          end
        end
        S_DRAIN: begin
          if (out_ready_i) begin
            if (out_idx_q == OUT_LAST) begin
              out_idx_q   <= '0;
              out_valid_q <= 1'b0;
              tile_cnt_q  <= tile_cnt_q + CNTW'(1);
              state_q     <= S_LOAD;
            end else begin
              out_idx_q <= out_idx_q + OUTW'(1);
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  for (genvar k = 0; k < NIN; k++) begin : g_pack
    assign core_d_o[k*W +: W] = core_d_q[k];
  end

  assign in_ready_o   = (state_q == S_LOAD);
  assign core_start_o = core_start_q;
  assign out_data_o   = res_q[out_idx_q];
  assign out_valid_o  = out_valid_q;
  assign busy_o       = (state_q != S_LOAD) || (in_idx_q != '0);
  assign tile_cnt_o   = tile_cnt_q;

endmodule

// File: tb/tb_wc_tile_seq.sv
// Randomized self-checking bench for wc_tile_seq; a simple core model returns the first NOUT
// tile words exactly LAT cycles after core_start and drives garbage on core_z otherwise.
module tb_wc_tile_seq;

  localparam int W    = 10;
  localparam int NIN  = 9;
  localparam int NOUT = 5;
  localparam int LAT  = 3;
  localparam int CNTW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [W*NIN-1:0]  core_d;
  logic              core_start;
  logic [W*NOUT-1:0] core_z;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [CNTW-1:0]   tile_cnt;

  logic [W*NOUT-1:0] zres;
  logic [W*NOUT-1:0] zgarb;
  logic [LAT-1:0]    sr;

  logic [W-1:0]      tile_w [NIN];
  logic [CNTW-1:0]   exp_cnt;
  int                n_cmp;
  int                n_err;

  wc_tile_seq #(.W(W), .NIN(NIN), .NOUT(NOUT), .LAT(LAT), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .core_d_o     (core_d),
    .core_start_o (core_start),
    .core_z_i     (core_z),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .tile_cnt_o   (tile_cnt)
  );

  always #5 clk = ~clk;

  // Core model: result word k equals tile word k, valid only in cycle start+LAT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr    <= (sr << 1) | LAT'(core_start);
      zgarb <= (W*NOUT)'({$urandom, $urandom});
      if (core_start)
        for (int k = 0; k < NOUT; k++) zres[k*W +: W] <= core_d[k*W +: W];
    end
  end
  assign core_z = sr[LAT-1] ? zres : zgarb;

  function automatic logic [W*NIN-1:0] pack_tile();
    logic [W*NIN-1:0] p;
    for (int k = 0; k < NIN; k++) p[k*W +: W] = tile_w[k];
    return p;
  endfunction

  task automatic new_tile();
    for (int k = 0; k < NIN; k++) tile_w[k] = W'($urandom);
  endtask

  // One complete tile: load with given duty, fire, wait, drain with a ready pattern
  // (0 always, 1 alternating from 1, 2 random). flush_at >= 0 aborts the drain there.
  task automatic run_tile(input int duty, input int rdy_mode, input bit hold_valid,
                          input int flush_at);
    int i, j, cyc;
    bit rdy;
    logic [W*NIN-1:0] exp_d;
    exp_d = pack_tile();
    i = 0;
    cyc = 0;
    while (i < NIN && cyc < 2000) begin
      in_valid = ($urandom_range(0, 99) < duty);
      in_data  = in_valid ? tile_w[i] : W'($urandom);
      if (in_valid && in_ready) i++;
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (i < NIN) begin
      n_err++;
      $display("FAIL load_timeout: accepted %0d words, want %0d", i, NIN);
      in_valid = 1'b0;
      return;
    end
    in_valid = hold_valid;
    in_data  = W'($urandom);
    n_cmp++;
    if ({core_start, in_ready, busy} !== 3'b101) begin
      n_err++;
      $display("FAIL fire_ctrl: start/ready/busy=%b want 101", {core_start, in_ready, busy});
    end
    n_cmp++;
    if (core_d !== exp_d) begin
      n_err++;
      $display("FAIL core_d_pack: got %h want %h", core_d, exp_d);
    end
    @(negedge clk);
    for (int c = 1; c <= LAT; c++) begin
      n_cmp++;
      if ({core_start, out_valid, in_ready} !== 3'b000) begin
        n_err++;
        $display("FAIL wait_ctrl c%0d: start/valid/ready=%b want 000", c,
                 {core_start, out_valid, in_ready});
      end
      in_data = W'($urandom);
      @(negedge clk);
    end
    j = 0;
    cyc = 0;
    while (j < NOUT && cyc < 200) begin
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b10 || out_data !== tile_w[j]) begin
        n_err++;
        $display("FAIL drain_word %0d: valid/ready=%b data=%h want 10 data=%h", j,
                 {out_valid, in_ready}, out_data, tile_w[j]);
      end
      if (flush_at == j) begin
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b001 || tile_cnt !== exp_cnt) begin
          n_err++;
          $display("FAIL drain_flush: valid/busy/ready=%b cnt=%0d want 001 cnt=%0d",
                   {out_valid, busy, in_ready}, tile_cnt, exp_cnt);
        end
        return;
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      in_data   = W'($urandom);
      if (rdy) j++;
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (j < NOUT) begin
      n_err++;
      $display("FAIL drain_timeout: drained %0d words, want %0d", j, NOUT);
    end
    exp_cnt++;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b010 || tile_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL tile_end: valid/ready/busy=%b cnt=%0d want 010 cnt=%0d",
               {out_valid, in_ready, busy}, tile_cnt, exp_cnt);
    end
    n_cmp++;
    if (core_d !== exp_d) begin
      n_err++;
      $display("FAIL core_d_hold: got %h want %h", core_d, exp_d);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    exp_cnt   = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({core_start, out_valid, busy, in_ready} !== 4'b0001 || core_d !== '0 ||
        out_data !== '0 || tile_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_values: s/v/b/r=%b core_d=%h out=%h cnt=%0d want 0001 0 0 0",
               {core_start, out_valid, busy, in_ready}, core_d, out_data, tile_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, busy} !== 2'b10 || tile_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_release: ready/busy=%b cnt=%0d want 10 cnt=0",
               {in_ready, busy}, tile_cnt);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < NIN; k++) tile_w[k] = W'(k + 1);
    run_tile(100, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    new_tile();
    run_tile(100, 1, 1'b0, -1);
    new_tile();
    run_tile(100, 2, 1'b0, -1);
  endtask

  task automatic test_gapped();
    for (int t = 0; t < 3; t++) begin
      new_tile();
      run_tile(50, t % 3, 1'b1, -1);
    end
  endtask

  task automatic test_flush();
    new_tile();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = tile_w[k];
      @(negedge clk);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL partial_busy: got %b want 1", busy);
    end
    flush   = 1'b1;
    in_data = W'($urandom);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({busy, in_ready} !== 2'b01 || tile_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL load_flush: busy/ready=%b cnt=%0d want 01 cnt=%0d",
               {busy, in_ready}, tile_cnt, exp_cnt);
    end
    new_tile();
    run_tile(100, 0, 1'b0, -1);
    new_tile();
    run_tile(100, 0, 1'b0, 2);
    new_tile();
    run_tile(70, 2, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    new_tile();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = tile_w[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    n_cmp++;
    if ({core_start, out_valid, busy, in_ready} !== 4'b0001 || core_d !== '0 ||
        out_data !== '0 || tile_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_async: s/v/b/r=%b core_d=%h out=%h cnt=%0d want 0001 0 0 0",
               {core_start, out_valid, busy, in_ready}, core_d, out_data, tile_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, busy} !== 2'b10 || tile_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_mid_release: ready/busy=%b cnt=%0d want 10 cnt=0",
               {in_ready, busy}, tile_cnt);
    end
    new_tile();
    run_tile(100, 0, 1'b0, -1);
  endtask

  task automatic test_wrap();
    do begin
      new_tile();
      run_tile(100, 0, 1'b0, -1);
    end while (exp_cnt != '0 && n_err < 20);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
